// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared definitions for the F-stage program counter logic.
//   - Default reset PC and instruction-memory window.
//   - Next-PC source select encodings (SEQ / BR / J / JR).
//   - Fetch FSM state encodings (RUN / HOLD).
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF       = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF        = 32'h0000_3000;
    localparam int unsigned IM_DEPTH_WORDS_DEF = 4096;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     f_pc_i         current fetch PC (sequential successor is f_pc_i+4)
//     d_pc_i         PC of the instruction in D (base for branch / jump)
//     imm16_i        signed word offset of a D-stage branch
//     instr_index_i  26-bit j/jal index
//     jr_target_i    forwarded rs value for jr/jalr
//     jump_reg_i, jump_i, if_branch_i   redirect requests from D
//     next_pc_o      selected next PC (redirect target or f_pc_i+4)
//     redirect_o     any redirect request is active
//     npc_sel_o      which source was selected
// ---------------------------------------------------------------------------
module npc_calc
    import cpu_defs::*;
(
    input  logic [31:0] f_pc_i,
    input  logic [31:0] d_pc_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_reg_i,
    input  logic        jump_i,
    input  logic        if_branch_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o,
    output npc_sel_e    npc_sel_o
);

    logic [31:0] d_pc_plus4;
    logic [31:0] br_offset;

    assign d_pc_plus4 = d_pc_i + 32'd4;
    assign br_offset  = {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign redirect_o = jump_reg_i | jump_i | if_branch_i;

    // Requests are expected one-hot; the priority chain makes the
    // outcome well defined if several are raised together.
    always_comb begin
        npc_sel_o = NPC_SEQ;
        if (jump_reg_i) begin
            npc_sel_o = NPC_JR;
        end else if (jump_i) begin
            npc_sel_o = NPC_J;
        end else if (if_branch_i) begin
            npc_sel_o = NPC_BR;
        end
    end

    always_comb begin
        next_pc_o = f_pc_i + 32'd4;
        case (npc_sel_o)
            NPC_JR:  next_pc_o = jr_target_i;
            NPC_J:   next_pc_o = {d_pc_plus4[31:28], instr_index_i, 2'b00};
            NPC_BR:  next_pc_o = d_pc_plus4 + br_offset;
            default: next_pc_o = f_pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   F-stage program counter of the 5-stage MIPS pipeline.
//   Holds the fetch PC, advances it (seq / branch / j / jr), freezes it on
//   hazard stalls and buffers one redirect that arrives while stalled.
//   Redirects never squash: the instruction at f_pc is the delay slot.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     stall               hazard unit freeze request
//     if_branch           D-stage branch taken
//     d_pc, imm16         branch base PC and signed word offset
//     jump, instr_index   D-stage j/jal and its index
//     jump_reg, jr_target D-stage jr/jalr and forwarded rs
//     f_pc                current fetch PC (IM address)
//     f_adel              f_pc misaligned or outside the IM window
//     redir_pend          a buffered redirect is waiting (FSM in HOLD)
//     fetch_count         PC advances since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_pc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE        = IM_BASE_DEF,
    parameter int unsigned IM_DEPTH_WORDS = IM_DEPTH_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_branch,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] f_pc,
    output logic        f_adel,
    output logic        redir_pend,
    output logic [31:0] fetch_count
);

    // 33-bit limit so a window ending at 2^32 still compares correctly.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH_WORDS) * 33'd4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [31:0]  next_pc;
    logic         redirect;
    npc_sel_e     npc_sel;

    npc_calc u_npc_calc (
        .f_pc_i        (pc_q),
        .d_pc_i        (d_pc),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .jr_target_i   (jr_target),
        .jump_reg_i    (jump_reg),
        .jump_i        (jump),
        .if_branch_i   (if_branch),
        .next_pc_o     (next_pc),
        .redirect_o    (redirect),
        .npc_sel_o     (npc_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    pc_d  = next_pc;
                    cnt_d = cnt_q + 32'd1;
                end else if (redirect) begin
                    // Capture the target now; D will have moved on by
                    // the time the stall releases.
                    pend_d  = next_pc;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The first captured target wins over anything D presents
                // later, including on the release cycle.
                if (!stall) begin
                    pc_d    = pend_q;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign f_pc        = pc_q;
    assign fetch_count = cnt_q;
    assign redir_pend  = (state_q == ST_HOLD);
    assign f_adel      = (pc_q[1:0] != 2'b00)
                       || ({1'b0, pc_q} < {1'b0, IM_BASE})
                       || ({1'b0, pc_q} >= IM_LIMIT);

    // Select encoding is only observed for debug; keep it referenced.
    logic npc_sel_unused;
    assign npc_sel_unused = ^npc_sel;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed bench for fetch_pc_unit with an architectural model of the
//   fetch PC (value, advance count, optional buffered target) that is
//   compared against the DUT on every falling edge, plus literal checks
//   taken straight from hand-computed scenarios.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_branch;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic        jump;
    logic [25:0] instr_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] f_pc;
    logic        f_adel;
    logic        redir_pend;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // -------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------
    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .if_branch   (if_branch),
        .d_pc        (d_pc),
        .imm16       (imm16),
        .jump        (jump),
        .instr_index (instr_index),
        .jump_reg    (jump_reg),
        .jr_target   (jr_target),
        .f_pc        (f_pc),
        .f_adel      (f_adel),
        .redir_pend  (redir_pend),
        .fetch_count (fetch_count)
    );

    // -------------------------------------------------------------------
    // Architectural model
    // -------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_pend_q[$];   // holds at most one buffered target

    function automatic logic [31:0] model_target();
        logic [31:0] np;
        logic signed [31:0] off;
        np  = d_pc + 32'd4;
        off = 32'($signed(imm16));
        if (jump_reg)       return jr_target;
        else if (jump)      return {np[31:28], instr_index, 2'b00};
        else if (if_branch) return d_pc + 32'd4 + 32'(off * 4);
        else                return m_pc + 32'd4;
    endfunction

    function automatic bit model_adel(logic [31:0] pc);
        longint p;
        p = longint'(pc);
        return (p % 4 != 0) || (p < 64'h3000) || (p >= 64'h3000 + 4 * 4096);
    endfunction

    always @(posedge clk) begin
        logic [31:0] tgt;
        if (reset) begin
            m_pc  = 32'h0000_3000;
            m_cnt = 0;
            m_pend_q.delete();
        end else if (m_pend_q.size() != 0) begin
            if (!stall) begin
                m_pc  = m_pend_q.pop_front();
                m_cnt = m_cnt + 1;
            end
        end else begin
            tgt = model_target();
            if (!stall) begin
                m_pc  = tgt;
                m_cnt = m_cnt + 1;
            end else if (jump_reg || jump || if_branch) begin
                m_pend_q.push_back(tgt);
            end
        end
    end

    // -------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_f_pc", f_pc, m_pc);
            chk("model_count", fetch_count, m_cnt);
            chk("model_redir_pend", 32'(redir_pend), 32'(m_pend_q.size() != 0));
            chk("model_f_adel", 32'(f_adel), 32'(model_adel(m_pc)));
        end
    end

    // -------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        if_branch   = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
        d_pc        = 32'h0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        jr_target   = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        cyc();
        chk_en = 1'b1;
        reset  = 1'b0;

        // 1. reset state and free run
        chk("rst_f_pc", f_pc, 32'h3000);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_pend", 32'(redir_pend), 32'd0);
        chk("rst_adel", 32'(f_adel), 32'd0);
        cyc(); chk("seq1", f_pc, 32'h3004);
        cyc(); chk("seq2", f_pc, 32'h3008);
        cyc(); chk("seq3", f_pc, 32'h300C);
        chk("seq_count", fetch_count, 32'd3);

        // 2. branches backward / forward
        d_pc = 32'h3004; imm16 = 16'hFFFF; if_branch = 1'b1;
        cyc(); chk("br_back", f_pc, 32'h3004);
        imm16 = 16'h0003;
        cyc(); chk("br_fwd", f_pc, 32'h3014);

        // 3. jump beats branch; jr to a misaligned target
        jump = 1'b1; d_pc = 32'h3010; instr_index = 26'h0000C10;
        cyc(); chk("j_prio", f_pc, 32'h3040);
        jump_reg = 1'b1; jr_target = 32'h3101;
        cyc(); chk("jr_mis", f_pc, 32'h3101);
        chk("jr_mis_adel", 32'(f_adel), 32'd1);
        chk("count7", fetch_count, 32'd7);

        // 4. redirect under stall is buffered; later targets ignored
        idle_inputs();
        stall = 1'b1; if_branch = 1'b1; d_pc = 32'h3000; imm16 = 16'h0007;
        cyc(); chk("hold_pc1", f_pc, 32'h3101);
        chk("hold_pend1", 32'(redir_pend), 32'd1);
        cyc(); chk("hold_cnt2", fetch_count, 32'd7);
        imm16 = 16'h001F;  // now 3080
        cyc(); chk("hold_pc3", f_pc, 32'h3101);
        stall = 1'b0;      // branch to 3080 still asserted on release
        cyc(); chk("rel_pc", f_pc, 32'h3020);
        chk("rel_pend", 32'(redir_pend), 32'd0);
        chk("rel_cnt", fetch_count, 32'd8);
        if_branch = 1'b0;
        cyc(); chk("after_rel", f_pc, 32'h3024);

        // stall without redirect freezes PC and counter
        stall = 1'b1;
        cyc(); chk("plain_stall_pc", f_pc, 32'h3024);
        chk("plain_stall_pend", 32'(redir_pend), 32'd0);
        chk("plain_stall_cnt", fetch_count, 32'd9);

        // 5. reset during HOLD discards the pending target
        if_branch = 1'b1; d_pc = 32'h3000; imm16 = 16'h0007;
        cyc(); chk("pre_rst_pend", 32'(redir_pend), 32'd1);
        reset = 1'b1;
        cyc(); chk("rst_hold_pc", f_pc, 32'h3000);
        chk("rst_hold_pend", 32'(redir_pend), 32'd0);
        chk("rst_hold_cnt", fetch_count, 32'd0);
        reset = 1'b0;
        idle_inputs();
        cyc(); chk("rst_hold_seq", f_pc, 32'h3004);

        // 6. wrap and IM window edges
        jump_reg = 1'b1; jr_target = 32'hFFFF_FFFC;
        cyc(); chk("top_pc", f_pc, 32'hFFFF_FFFC);
        chk("top_adel", 32'(f_adel), 32'd1);
        jump_reg = 1'b0;
        cyc(); chk("wrap_pc", f_pc, 32'h0000_0000);
        chk("wrap_adel", 32'(f_adel), 32'd1);
        jump_reg = 1'b1; jr_target = 32'h2FFC;
        cyc(); chk("below_adel", 32'(f_adel), 32'd1);
        jr_target = 32'h6FFC;
        cyc(); chk("last_adel", 32'(f_adel), 32'd0);
        jr_target = 32'h7000;
        cyc(); chk("past_adel", 32'(f_adel), 32'd1);
        jr_target = 32'h3000;
        cyc(); chk("base_adel", 32'(f_adel), 32'd0);
        idle_inputs();
        cyc(); cyc();
        chk("final_pc", f_pc, 32'h3008);
        chk("final_cnt", fetch_count, 32'd9);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
